cordic_engine: RTL and testbench
================================

Name: cordic_engine

Overview:
Iterative, handshaked CORDIC engine for the CORDIC module family. It computes one micro-rotation per clock and supports two runtime modes: rotation (rotate X/Y by an angle) and vectoring (magnitude plus atan2). Operand width and iteration count are parameters. Ready/valid ports on both sides let it sit between a bus-facing register front end and downstream consumers, with backpressure. Output gain is not compensated; gain compensation is the consumer's job.

Parameters:
BIT_WIDTH, 16, signed width of Xin/Yin; legal range 4..30.
ITERATIONS, 16, number of micro-rotations; legal range 1..30; elaboration error if out of range.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input operands valid.
in_ready  out  1  engine can accept; high only in IDLE and never while rst=1.
mode  in  1  0 = rotation, 1 = vectoring; captured on accept.
Xin  in  BIT_WIDTH  signed X operand.
Yin  in  BIT_WIDTH  signed Y operand.
angle  in  32  signed binary angle; full circle = 2^32, 0x20000000 = 45 deg.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
Xout  out  BIT_WIDTH+2  signed X result.
Yout  out  BIT_WIDTH+2  signed Y result.
Zout  out  32  residual angle (rotation) or accumulated angle (vectoring).
busy  out  1  high in ITER or DONE.

Behaviour:
- FSM states: IDLE, ITER, DONE. rst forces IDLE on the next edge.
- rst also clears: iteration counter, out_valid, Xout, Yout, Zout.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: load the pre-rotated X/Y/Z into internal registers, latch mode, clear counter, go to ITER.
- Pre-rotation in rotation mode, keyed on angle[31:30]:
  - 00 or 11: X=Xin, Y=Yin, Z=angle.
  - 01: X=-Yin, Y=Xin, Z=angle-0x40000000.
  - 10: X=Yin, Y=-Xin, Z=angle+0x40000000.
- Pre-rotation in vectoring mode:
  - Xin>=0: no change.
  - Xin<0 and Yin>=0: X=Yin, Y=-Xin, Z=angle+0x40000000.
  - Xin<0 and Yin<0: X=-Yin, Y=Xin, Z=angle-0x40000000.
- ITER, iteration i = counter:
  - Direction d=+1 when (rotation: Z>=0) or (vectoring: Y<0); otherwise d=-1.
  - X' = X - d*(Y>>>i); Y' = Y + d*(X>>>i); Z' = Z - d*atan[i].
  - At the edge where counter==ITERATIONS-1: register the results to the outputs, set out_valid, go to DONE.
- atan table: atan[i] = round(atan(2^-i)*2^32/(2*pi)), i = 0..29, constant ROM. First entries: 0x20000000, 0x12E4051E, 0x09FB385B, 0x051111D4.
- Widths:
  - X/Y internal registers are BIT_WIDTH+2 bits, sign-extended on load, so negating -2^(BIT_WIDTH-1) cannot overflow.
  - Shifts are arithmetic.
  - Z uses wrap-around 32-bit arithmetic.
- Latency: out_valid rises exactly ITERATIONS cycles after the accept edge.
- DONE:
  - out_valid=1; Xout, Yout and Zout are held stable until out_valid&&out_ready.
  - On that edge: out_valid=0, go to IDLE.
  - Back-to-back throughput is one result per ITERATIONS+2 cycles.
- in_valid while busy is ignored (not accepted, not queued).
- rst during ITER or DONE aborts the operation:
  - No out_valid is ever produced for the aborted operands.
  - in_ready rises the first cycle after rst deasserts.
- Results carry the CORDIC gain K ≈ 1.6468 for ITERATIONS>=8.
  - Rotation: Xout ≈ K(x·cosθ - y·sinθ), Yout ≈ K(x·sinθ + y·cosθ).
  - Vectoring: Xout ≈ K·sqrt(x²+y²), Yout ≈ 0, Zout ≈ angle + atan2(y,x).

Test Plan:
All scenarios use BIT_WIDTH=16, ITERATIONS=16.
- Rotation, mode=0, Xin=10000, Yin=0, angle=0x15555555 (30 deg) -> Xout≈14262, Yout≈8234 (±4 LSB); out_valid exactly 16 cycles after the accept edge.
- Quadrant pre-rotation, mode=0, Xin=10000, Yin=0, angle=0x60000000 (135 deg) -> Xout≈-11645, Yout≈11645 (±4).
- Vectoring, mode=1, Xin=-3000, Yin=4000, angle=0 -> Xout≈8234 (±4), |Yout|<=2, Zout≈0x5A37F5C1 (±0x20000).
- Backpressure: out_ready=0 for 5 cycles in DONE, in_valid=1 throughout -> outputs constant, in_ready=0, no second accept; then out_ready=1 -> IDLE, and the next operand is accepted the following cycle.
- Reset abort: rst pulsed 1 cycle at iteration 5 -> out_valid stays 0, all outputs read 0, in_ready=1 the cycle after rst deasserts; a fresh operation then returns correct results.
- Extremes, mode=0, Xin=Yin=-32768, angle=0 -> Xout≈Yout≈-53962 (±4), no wrap or overflow.

Source files
------------

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or
// vectoring mode selected per operation, ready/valid on both sides.
// Results carry the uncompensated CORDIC gain.
module cordic_engine #(
   parameter int BIT_WIDTH  = 16,
   parameter int ITERATIONS = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        mode,
   input  logic signed [BIT_WIDTH-1:0] Xin,
   input  logic signed [BIT_WIDTH-1:0] Yin,
   input  logic [31:0]                 angle,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [BIT_WIDTH+1:0] Xout,
   output logic signed [BIT_WIDTH+1:0] Yout,
   output logic [31:0]                 Zout,
   output logic                        busy
);

   localparam int XW = BIT_WIDTH + 2;

   generate
      if (ITERATIONS < 1 || ITERATIONS > 30) begin : g_bad_iterations
         $error("cordic_engine: ITERATIONS must be in 1..30");
      end
      if (BIT_WIDTH < 4 || BIT_WIDTH > 30) begin : g_bad_width
         $error("cordic_engine: BIT_WIDTH must be in 4..30");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic signed [XW-1:0] x_q, y_q;
   logic [31:0]          z_q;
   logic                 mode_q;
   logic [4:0]           cnt_q;
   logic signed [XW-1:0] xout_q, yout_q;
   logic [31:0]          zout_q;
   logic                 out_valid_q;

   logic signed [XW-1:0] xin_ext, yin_ext;
   logic signed [XW-1:0] x_pre, y_pre;
   logic [31:0]          z_pre;
   logic signed [XW-1:0] x_sh, y_sh, x_nxt, y_nxt;
   logic [31:0]          z_nxt, atan_i;
   logic                 d_pos, last_iter, accept;

   // atan(2^-i) scaled so that a full circle is 2^32, i = 0..29
   function automatic logic [31:0] atan_lut(input logic [4:0] idx);
      case (idx)
         5'd0:    atan_lut = 32'h2000_0000;
         5'd1:    atan_lut = 32'h12E4_051E;
         5'd2:    atan_lut = 32'h09FB_385B;
         5'd3:    atan_lut = 32'h0511_11D4;
         5'd4:    atan_lut = 32'h028B_0D43;
         5'd5:    atan_lut = 32'h0145_D7E1;
         5'd6:    atan_lut = 32'h00A2_F61E;
         5'd7:    atan_lut = 32'h0051_7C55;
         5'd8:    atan_lut = 32'h0028_BE53;
         5'd9:    atan_lut = 32'h0014_5F2F;
         5'd10:   atan_lut = 32'h000A_2F98;
         5'd11:   atan_lut = 32'h0005_17CC;
         5'd12:   atan_lut = 32'h0002_8BE6;
         5'd13:   atan_lut = 32'h0001_45F3;
         5'd14:   atan_lut = 32'h0000_A2FA;
         5'd15:   atan_lut = 32'h0000_517D;
         5'd16:   atan_lut = 32'h0000_28BE;
         5'd17:   atan_lut = 32'h0000_145F;
         5'd18:   atan_lut = 32'h0000_0A30;
         5'd19:   atan_lut = 32'h0000_0518;
         5'd20:   atan_lut = 32'h0000_028C;
         5'd21:   atan_lut = 32'h0000_0146;
         5'd22:   atan_lut = 32'h0000_00A3;
         5'd23:   atan_lut = 32'h0000_0051;
         5'd24:   atan_lut = 32'h0000_0029;
         5'd25:   atan_lut = 32'h0000_0014;
         5'd26:   atan_lut = 32'h0000_000A;
         5'd27:   atan_lut = 32'h0000_0005;
         5'd28:   atan_lut = 32'h0000_0003;
         5'd29:   atan_lut = 32'h0000_0001;
         default: atan_lut = 32'h0000_0000;
      endcase
   endfunction

   // Two guard bits so negating the most negative operand stays in range
   assign xin_ext = {{2{Xin[BIT_WIDTH-1]}}, Xin};
   assign yin_ext = {{2{Yin[BIT_WIDTH-1]}}, Yin};

   // Quadrant pre-rotation brings the problem into the +/-90 degree convergence range
   always_comb begin
      x_pre = xin_ext;
      y_pre = yin_ext;
      z_pre = angle;
      if (!mode) begin
         case (angle[31:30])
            2'b01: begin
               x_pre = -yin_ext;
               y_pre = xin_ext;
               z_pre = angle - 32'h4000_0000;
            end
            2'b10: begin
               x_pre = yin_ext;
               y_pre = -xin_ext;
               z_pre = angle + 32'h4000_0000;
            end
            default: ;
         endcase
      end else if (Xin[BIT_WIDTH-1]) begin
         if (!Yin[BIT_WIDTH-1]) begin
            x_pre = yin_ext;
            y_pre = -xin_ext;
            z_pre = angle + 32'h4000_0000;
         end else begin
            x_pre = -yin_ext;
            y_pre = xin_ext;
            z_pre = angle - 32'h4000_0000;
         end
      end
   end

   // One micro-rotation; direction follows Z sign (rotation) or Y sign (vectoring)
   always_comb begin
      atan_i = atan_lut(cnt_q);
      x_sh   = x_q >>> cnt_q;
      y_sh   = y_q >>> cnt_q;
      d_pos  = mode_q ? y_q[XW-1] : ~z_q[31];
      if (d_pos) begin
         x_nxt = x_q - y_sh;
         y_nxt = y_q + x_sh;
         z_nxt = z_q - atan_i;
      end else begin
         x_nxt = x_q + y_sh;
         y_nxt = y_q - x_sh;
         z_nxt = z_q + atan_i;
      end
   end

   assign last_iter = (cnt_q == 5'(ITERATIONS - 1));
   assign accept    = in_valid && in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and handshake outputs
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = !rst;
            if (in_valid) state_d = ITER;
         end
         ITER: begin
            busy = 1'b1;
            if (last_iter) state_d = DONE;
         end
         DONE: begin
            busy = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Working registers, iteration counter and held results
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         mode_q      <= 1'b0;
         cnt_q       <= '0;
         xout_q      <= '0;
         yout_q      <= '0;
         zout_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  x_q    <= x_pre;
                  y_q    <= y_pre;
                  z_q    <= z_pre;
                  mode_q <= mode;
                  cnt_q  <= '0;
               end
            end
            ITER: begin
               x_q   <= x_nxt;
               y_q   <= y_nxt;
               z_q   <= z_nxt;
               cnt_q <= cnt_q + 5'd1;
               if (last_iter) begin
                  xout_q      <= x_nxt;
                  yout_q      <= y_nxt;
                  zout_q      <= z_nxt;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign Xout      = xout_q;
   assign Yout      = yout_q;
   assign Zout      = zout_q;

endmodule

// File: tb/tb_cordic_engine.sv
// Randomized self-checking bench for cordic_engine (BIT_WIDTH=16, ITERATIONS=16).
// Reference: textbook CORDIC on wide integers with an arctangent table
// computed from real-valued $atan, plus the expected physical results.
module tb_cordic_engine;

   localparam int BW = 16;
   localparam int IT = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic                 mode = 1'b0;
   logic signed [BW-1:0] Xin = '0;
   logic signed [BW-1:0] Yin = '0;
   logic [31:0]          angle = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic signed [BW+1:0] Xout, Yout;
   logic [31:0]          Zout;
   logic                 busy;

   int    n_vectors = 0;
   int    n_miscompares = 0;
   longint atan_tab[IT];

   cordic_engine #(.BIT_WIDTH(BW), .ITERATIONS(IT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .Xin(Xin), .Yin(Yin), .angle(angle),
      .out_valid(out_valid), .out_ready(out_ready),
      .Xout(Xout), .Yout(Yout), .Zout(Zout), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input longint got, input longint exp, input longint tol);
      n_vectors++;
      if ((got - exp > tol) || (exp - got > tol)) begin
         n_miscompares++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   // Behavioural CORDIC: quadrant fold, then IT micro-rotations on wide integers
   function automatic void model(input bit m, input longint xi, input longint yi, input logic [31:0] a,
                                 output longint xo, output longint yo, output logic [31:0] zo);
      longint x, y, xn;
      logic [31:0] z;
      bit d;
      x = xi; y = yi; z = a;
      if (!m) begin
         if (a[31:30] == 2'b01) begin x = -yi; y = xi; z = a - 32'h4000_0000; end
         else if (a[31:30] == 2'b10) begin x = yi; y = -xi; z = a + 32'h4000_0000; end
      end else if (xi < 0) begin
         if (yi >= 0) begin x = yi; y = -xi; z = a + 32'h4000_0000; end
         else begin x = -yi; y = xi; z = a - 32'h4000_0000; end
      end
      for (int i = 0; i < IT; i++) begin
         d = m ? (y < 0) : ($signed(z) >= 0);
         if (d) begin
            xn = x - (y >>> i); y = y + (x >>> i); z = z - 32'(atan_tab[i]);
         end else begin
            xn = x + (y >>> i); y = y - (x >>> i); z = z + 32'(atan_tab[i]);
         end
         x = xn;
      end
      xo = x; yo = y; zo = z;
   endfunction

   // Present operands; returns at the negedge just after the accept edge
   task automatic send(input bit m, input logic signed [BW-1:0] x, input logic signed [BW-1:0] y,
                       input logic [31:0] a, input bit hold);
      int w;
      mode = m; Xin = x; Yin = y; angle = a; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin @(negedge clk); w++; end
      check("in_ready_before_accept", longint'(in_ready), 1, 0);
      @(negedge clk);
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      while (!out_valid && k < 100) begin @(negedge clk); k++; end
   endtask

   task automatic run(input string tag, input bit m, input logic signed [BW-1:0] x,
                      input logic signed [BW-1:0] y, input logic [31:0] a,
                      output longint xo, output longint yo, output logic [31:0] zo);
      int k;
      longint ex, ey;
      logic [31:0] ez;
      model(m, longint'(x), longint'(y), a, ex, ey, ez);
      send(m, x, y, a, 1'b0);
      wait_valid(k);
      check({tag, "_latency"}, k, IT, 0);
      xo = longint'(Xout); yo = longint'(Yout); zo = Zout;
      check({tag, "_x"}, xo, ex, 0);
      check({tag, "_y"}, yo, ey, 0);
      check({tag, "_z"}, longint'(zo), longint'(ez), 0);
      $display("op %s mode=%0d x=%0d y=%0d a=%h -> X=%0d Y=%0d Z=%h lat=%0d",
               tag, m, x, y, a, xo, yo, zo, k);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, longint'(out_valid), 0, 0);
   endtask

   initial begin
      longint xo, yo, ex, ey, sx, sy;
      logic [31:0] zo, ez, sz;
      int k, seen;
      real p;
      bit m;
      logic signed [BW-1:0] rx, ry;
      logic [31:0] ra;

      p = 1.0;
      for (int i = 0; i < IT; i++) begin
         atan_tab[i] = longint'($rtoi($atan(p) * 4294967296.0 / (2.0 * 3.14159265358979323846) + 0.5));
         p = p / 2.0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", longint'(in_ready), 0, 0);
      check("rst_out_valid", longint'(out_valid), 0, 0);
      check("rst_busy", longint'(busy), 0, 0);
      check("rst_xout", longint'(Xout), 0, 0);
      check("rst_zout", longint'(Zout), 0, 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", longint'(in_ready), 1, 0);
      @(negedge clk);

      // Directed cases with physically expected results
      run("rot30", 1'b0, 16'sd10000, 16'sd0, 32'h1555_5555, xo, yo, zo);
      check("rot30_x_phys", xo, 14262, 4);
      check("rot30_y_phys", yo, 8234, 4);

      run("rot135", 1'b0, 16'sd10000, 16'sd0, 32'h6000_0000, xo, yo, zo);
      check("rot135_x_phys", xo, -11645, 4);
      check("rot135_y_phys", yo, 11645, 4);

      run("vec", 1'b1, -16'sd3000, 16'sd4000, 32'h0, xo, yo, zo);
      check("vec_mag_phys", xo, 8234, 4);
      check("vec_y_phys", yo, 0, 2);
      check("vec_z_phys", longint'($signed(zo - 32'h5A37_F5C1)), 0, 32'h20000);

      run("extreme", 1'b0, -16'sd32768, -16'sd32768, 32'h0, xo, yo, zo);
      check("extreme_x_phys", xo, -53962, 4);
      check("extreme_y_phys", yo, -53962, 4);

      // Randomized operations
      for (int n = 0; n < 24; n++) begin
         m  = 1'($urandom);
         rx = 16'($urandom);
         ry = 16'($urandom);
         ra = $urandom;
         run("rand", m, rx, ry, ra, xo, yo, zo);
      end

      // Backpressure with in_valid held high throughout
      rx = 16'sd5000; ry = -16'sd7000; ra = 32'hA123_4567;
      model(1'b0, longint'(rx), longint'(ry), ra, ex, ey, ez);
      send(1'b0, rx, ry, ra, 1'b1);
      wait_valid(k);
      check("bp_latency", k, IT, 0);
      check("bp_x", longint'(Xout), ex, 0);
      check("bp_y", longint'(Yout), ey, 0);
      check("bp_z", longint'(Zout), longint'(ez), 0);
      sx = longint'(Xout); sy = longint'(Yout); sz = Zout;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_hold_x", longint'(Xout), sx, 0);
         check("bp_hold_y", longint'(Yout), sy, 0);
         check("bp_hold_z", longint'(Zout), longint'(sz), 0);
         check("bp_in_ready", longint'(in_ready), 0, 0);
         check("bp_out_valid", longint'(out_valid), 1, 0);
      end
      $display("op bp mode=0 x=%0d y=%0d a=%h -> X=%0d Y=%0d Z=%h held 5 cycles", rx, ry, ra, sx, sy, sz);
      rx = -16'sd1234; ry = 16'sd2345; ra = 32'h1000_0000;
      mode = 1'b1; Xin = rx; Yin = ry; angle = ra;
      model(1'b1, longint'(rx), longint'(ry), ra, ex, ey, ez);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_release_valid", longint'(out_valid), 0, 0);
      check("bp_release_in_ready", longint'(in_ready), 1, 0);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_next_accepted", longint'(busy), 1, 0);
      wait_valid(k);
      check("bp_next_latency", k, IT, 0);
      check("bp_next_x", longint'(Xout), ex, 0);
      check("bp_next_y", longint'(Yout), ey, 0);
      check("bp_next_z", longint'(Zout), longint'(ez), 0);
      $display("op bp_next mode=1 x=%0d y=%0d a=%h -> X=%0d Y=%0d Z=%h lat=%0d", rx, ry, ra, Xout, Yout, Zout, k);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset abort at iteration 5
      send(1'b0, 16'sd8000, 16'sd3000, 32'h2222_2222, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_in_ready_during_rst", longint'(in_ready), 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_out_valid", longint'(out_valid), 0, 0);
      check("abort_xout", longint'(Xout), 0, 0);
      check("abort_yout", longint'(Yout), 0, 0);
      check("abort_zout", longint'(Zout), 0, 0);
      check("abort_busy", longint'(busy), 0, 0);
      check("abort_in_ready", longint'(in_ready), 1, 0);
      seen = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort_no_result", seen, 0, 0);
      $display("op abort mode=0 x=8000 y=3000 a=22222222 -> aborted, stray valids=%0d", seen);
      run("after_abort", 1'b0, 16'sd10000, 16'sd0, 32'h1555_5555, xo, yo, zo);
      check("after_abort_x_phys", xo, 14262, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
